if_id_buf: RTL and testbench
============================

Name: if_id_buf

Overview:
- Decoupling stage directly downstream of the fetch unit; captures each fetched instruction/PC pair and presents it to the decode stage.
- Two-entry skid FIFO with valid/ready handshakes on both sides, so a decode stall never drops a fetched instruction.
- Taken jump/branch acts as a flush that kills all buffered (wrong-path) instructions.
- Presents a canonical NOP to decode whenever it is empty.

Parameters:
INST_W, 32, instruction width (matches instruction bus)
ADDR_W, 64, instruction address / PC width (matches instruction address bus)
NOP_INST, 32'h0000_0013, encoding driven on out_inst when empty (addi x0,x0,0)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  fetch side presents a valid instruction this cycle
in_ready  output  1  buffer can accept; push = in_valid & in_ready
in_inst  input  INST_W  fetched instruction
in_pc  input  ADDR_W  PC of in_inst
flush  input  1  taken jump/branch resolved; discard all buffered and incoming entries
out_valid  output  1  decode side has a valid instruction
out_ready  input  1  decode consumes; pop = out_valid & out_ready
out_inst  output  INST_W  head instruction, NOP_INST when empty
out_pc  output  ADDR_W  head PC, 0 when empty
occ  output  2  current occupancy, 0..2

Behaviour:
- Storage: two entries {inst, pc}, 1-bit wr_ptr, 1-bit rd_ptr, 2-bit count. All registers clear asynchronously when rst=0: pointers 0, count 0, entry data 0.
- Reset values: out_valid=0, occ=0, out_inst=NOP_INST, out_pc=0. in_ready=1 while rst=1 and count<2. in_ready=0 while rst=0.
- Combinational outputs:
  - in_ready = (count != 2).
  - out_valid = (count != 0).
  - occ = count.
  - out_inst/out_pc = entry[rd_ptr] when count!=0, else NOP_INST / 0.
- No combinational path from in_* to out_*; from out_ready to in_ready; or from flush to any output.
- Latency: an instruction pushed at edge N appears on out_* with out_valid=1 in the cycle after edge N (1-cycle latency). Program order is strictly preserved.
- Push: write entry[wr_ptr] <= {in_inst, in_pc}; wr_ptr toggles (wraps 1->0).
- Pop: rd_ptr toggles (wraps 1->0).
- Count update, flush=0:
  - push only: +1
  - pop only: -1
  - push & pop: unchanged (legal at count=1; at count=0 pop impossible; at count=2 push impossible)
- Full (count=2): in_ready=0; upstream must hold in_* stable. A pop this cycle frees space visible next cycle only (in_ready does not depend on out_ready).
- Empty (count=0): out_valid=0; out_ready ignored.
- Flush (highest priority): at the edge where flush=1:
  - count<=0 and wr_ptr<=rd_ptr<=0.
  - Any simultaneous push is discarded.
  - Any simultaneous pop still counts as consumed by decode.
  - Entry data unchanged (don't-care).
  - The next cycle shows out_valid=0 and the NOP.
- Flush held for several cycles: buffer stays empty; all pushes are dropped while flush=1.
- Reset mid-operation: asynchronous clear immediately forces empty outputs regardless of clock; the first push after rst deasserts behaves as from power-up.
- Widths: count never exceeds 2; pointer arithmetic is 1-bit modulo. Entries store INST_W/ADDR_W bits unmodified.

Test Plan:
- Reset: rst=0 mid-stream with count=2 -> same cycle out_valid=0, occ=0, out_inst=32'h13, out_pc=0; after rst=1, in_ready=1.
- Streaming: out_ready=1, push inst 0x00100093 @pc 0x80000000 then 0x00200113 @0x80000004 on consecutive cycles -> each appears one cycle later in order; occ stays 1; no bubbles.
- Backpressure/full: out_ready=0, push A, B, C -> after two pushes occ=2, in_ready=0, C held; then raise out_ready -> A, B, C emerge in order, none lost or duplicated.
- Pointer wrap: alternate push/pop for 5 instructions at count=1 -> pointers wrap ≥2 times; output order matches input order, PCs 0x80000000..0x80000010.
- Flush with simultaneous push: count=2 (A, B), flush=1 with in_valid=1 (C) -> next cycle occ=0, out_valid=0, out_inst=NOP; C never appears; next push D @0x80000100 emerges next.
- Simultaneous push+pop at count=1: head A popped while B pushed -> occ stays 1, out shows B next cycle.

Source files
------------

// File: rtl/if_id_buf.sv
// IF/ID decoupling buffer: two-entry skid FIFO between fetch and decode.
// A flush drops every buffered and incoming wrong-path instruction. Decode sees a NOP while the buffer is empty.
module if_id_buf #(
   parameter int                INST_W   = 32,
   parameter int                ADDR_W   = 64,
   parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] in_inst,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [ADDR_W-1:0] out_pc,
   output logic [1:0]        occ
);

   logic [INST_W-1:0] entry_inst [2];
   logic [ADDR_W-1:0] entry_pc   [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic              push;
   logic              pop;

   // in_ready is forced low while reset is held. It never depends on out_ready.
   assign in_ready  = rst && (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign occ       = count;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      out_inst = NOP_INST;
      out_pc   = '0;
      if (count != 2'd0) begin
         out_inst = entry_inst[rd_ptr];
         out_pc   = entry_pc[rd_ptr];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the two entries are small enough to clear on reset like ordinary registers; larger RAMs normally are not reset.
         for (int i = 0; i < 2; i++) begin
            entry_inst[i] <= '0;
            entry_pc[i]   <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         // Flush overrides push and pop. A concurrent pop has still been consumed by decode.
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            entry_inst[wr_ptr] <= in_inst;
            entry_pc[wr_ptr]   <= in_pc;
            wr_ptr             <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_if_id_buf.sv
// Directed self-checking bench for if_id_buf.
// Inputs are driven 1 ns after each rising edge, and outputs are checked at that same point.
module tb_if_id_buf;

   localparam int INST_W = 32;
   localparam int ADDR_W = 64;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [INST_W-1:0] in_inst;
   logic [ADDR_W-1:0] in_pc;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [INST_W-1:0] out_inst;
   logic [ADDR_W-1:0] out_pc;
   logic [1:0]        occ;

   int checks = 0;
   int errors = 0;

   if_id_buf #(.INST_W(INST_W), .ADDR_W(ADDR_W), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
      .occ(occ)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc);
      in_valid = v;
      in_inst  = inst;
      in_pc    = pc;
   endtask

   task automatic expect_empty(input string tag);
      check({tag, "_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_occ"},   64'(occ),       64'd0);
      check({tag, "_inst"},  64'(out_inst),  64'(NOP));
      check({tag, "_pc"},    out_pc,         64'd0);
   endtask

   task automatic expect_head(input string tag, input logic [31:0] inst, input logic [63:0] pc,
                              input logic [1:0] n);
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_inst"},  64'(out_inst),  64'(inst));
      check({tag, "_pc"},    out_pc,         pc);
      check({tag, "_occ"},   64'(occ),       64'(n));
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, '0, '0);

      // Power-up reset
      #1;
      expect_empty("por");
      check("por_in_ready", 64'(in_ready), 64'd0);
      tick(); tick();
      rst = 1'b1;
      #1;
      check("rel_in_ready", 64'(in_ready), 64'd1);

      // Streaming with decode always ready: one-cycle latency and no bubbles
      tick();
      out_ready = 1'b1;
      drive(1'b1, 32'h0010_0093, 64'h8000_0000);
      tick();
      expect_head("str_a", 32'h0010_0093, 64'h8000_0000, 2'd1);
      drive(1'b1, 32'h0020_0113, 64'h8000_0004);
      tick();
      expect_head("str_b", 32'h0020_0113, 64'h8000_0004, 2'd1);
      drive(1'b0, '0, '0);
      tick();
      expect_empty("str_end");

      // Backpressure: push A and B, hold C while full, then drain
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_00A1, 64'h8000_0020);
      tick();
      expect_head("bp_a", 32'h0000_00A1, 64'h8000_0020, 2'd1);
      drive(1'b1, 32'h0000_00B2, 64'h8000_0024);
      tick();
      expect_head("bp_full", 32'h0000_00A1, 64'h8000_0020, 2'd2);
      check("bp_full_ready", 64'(in_ready), 64'd0);
      drive(1'b1, 32'h0000_00C3, 64'h8000_0028);
      tick();
      expect_head("bp_hold", 32'h0000_00A1, 64'h8000_0020, 2'd2);
      out_ready = 1'b1;
      check("bp_ready_indep", 64'(in_ready), 64'd0);
      tick();
      expect_head("bp_b", 32'h0000_00B2, 64'h8000_0024, 2'd1);
      check("bp_space", 64'(in_ready), 64'd1);
      tick();
      expect_head("bp_c", 32'h0000_00C3, 64'h8000_0028, 2'd1);
      drive(1'b0, '0, '0);
      tick();
      expect_empty("bp_end");

      // Pointer wrap: a push and a pop every cycle for five instructions
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h0000_0100 + 32'(i), 64'h8000_0000 + 64'(4 * i));
         tick();
         expect_head($sformatf("wrap%0d", i), 32'h0000_0100 + 32'(i), 64'h8000_0000 + 64'(4 * i), 2'd1);
      end
      drive(1'b0, '0, '0);
      tick();
      expect_empty("wrap_end");

      // Flush at full with a simultaneous push: C is dropped and D comes out next
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_0A0A, 64'h8000_0040);
      tick();
      drive(1'b1, 32'h0000_0B0B, 64'h8000_0044);
      tick();
      check("fl_full_occ", 64'(occ), 64'd2);
      drive(1'b1, 32'h0000_0C0C, 64'h8000_0048);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      expect_empty("fl_full");
      drive(1'b1, 32'h0000_0D0D, 64'h8000_0100);
      tick();
      expect_head("fl_d", 32'h0000_0D0D, 64'h8000_0100, 2'd1);

      // Flush held for two cycles while pushing with decode ready: everything is dropped
      out_ready = 1'b1;
      drive(1'b1, 32'h0000_0E0E, 64'h8000_0104);
      flush = 1'b1;
      tick();
      expect_empty("fl_hold1");
      tick();
      expect_empty("fl_hold2");
      flush = 1'b0;
      drive(1'b0, '0, '0);
      tick();
      expect_empty("fl_after");

      // Simultaneous push and pop at count 1
      out_ready = 1'b0;
      drive(1'b1, 32'h1111_1111, 64'h8000_0200);
      tick();
      expect_head("pp_a", 32'h1111_1111, 64'h8000_0200, 2'd1);
      out_ready = 1'b1;
      drive(1'b1, 32'h2222_2222, 64'h8000_0204);
      tick();
      expect_head("pp_b", 32'h2222_2222, 64'h8000_0204, 2'd1);

      // Asynchronous reset in mid-cycle while full, then push again as from power-up
      out_ready = 1'b0;
      drive(1'b1, 32'h3333_3333, 64'h8000_0208);
      tick();
      check("rst_pre_occ", 64'(occ), 64'd2);
      drive(1'b0, '0, '0);
      #3 rst = 1'b0;
      #1;
      expect_empty("rst_mid");
      check("rst_mid_ready", 64'(in_ready), 64'd0);
      #1 rst = 1'b1;
      #1;
      check("rst_rel_ready", 64'(in_ready), 64'd1);
      tick();
      drive(1'b1, 32'h4444_4444, 64'h8000_0300);
      tick();
      expect_head("rst_first", 32'h4444_4444, 64'h8000_0300, 2'd1);
      drive(1'b0, '0, '0);
      out_ready = 1'b1;
      tick();
      expect_empty("rst_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
